// File: rtl/lockstep_fault_ctrl.sv
// lockstep_fault_ctrl: recovery sequencer for a dual-core lockstep pair
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   mismatch_now      combinational compare result from the lockstep pair
//   fault_clr         software clear pulse (zeroes retry_cnt, releases SAFE)
//   inj_req           fault-injection request, present only with LS_FAULT_INJECT_EN
//   core_rst          reset to both cores
//   cmp_mask          1 while the comparator result is ignored
//   fault_irq         one-cycle pulse per accepted mismatch
//   fatal             1 while parked in SAFE
//   state             0 RUN, 1 RESET, 2 SETTLE, 3 SAFE
//   retry_cnt         recoveries since last clear/heal
//   fault_total       lifetime accepted mismatches, saturating
// Optional feature macro: LS_FAULT_INJECT_EN
module lockstep_fault_ctrl #(
    parameter int unsigned RST_CYCLES    = 4,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned HEAL_CYCLES   = 1024,
    parameter int unsigned CNT_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mismatch_now,
    input  logic             fault_clr,
`ifdef LS_FAULT_INJECT_EN
    input  logic             inj_req,
`endif
    output logic             core_rst,
    output logic             cmp_mask,
    output logic             fault_irq,
    output logic             fatal,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [15:0]      fault_total
);
    typedef enum logic [1:0] {S_RUN = 2'd0, S_RST = 2'd1, S_SETTLE = 2'd2, S_SAFE = 2'd3} state_t;
    localparam int unsigned TMAX = RST_CYCLES > SETTLE_CYCLES ? RST_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TW = TMAX > 1 ? $clog2(TMAX) : 1;
    localparam int unsigned HW = HEAL_CYCLES > 1 ? $clog2(HEAL_CYCLES) : 1;
    localparam logic [TW-1:0] T_RST = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] T_SET = TW'(SETTLE_CYCLES - 1);
    localparam logic [HW-1:0] HEAL_LAST = HW'(HEAL_CYCLES == 0 ? 0 : HEAL_CYCLES - 1);
    localparam logic [CNT_W-1:0] RETRY_MAX = CNT_W'(MAX_RETRY);
    state_t st, st_n;
    logic [TW-1:0] timer, timer_n;
    logic [HW-1:0] heal, heal_n;
    logic [CNT_W-1:0] retry_n;
    logic [15:0] total_n;
    logic irq_n, hit;
`ifdef LS_FAULT_INJECT_EN
    assign hit = mismatch_now | inj_req;
`else
    assign hit = mismatch_now;
`endif
    always_comb begin
        st_n    = st;
        timer_n = timer;
        retry_n = fault_clr ? '0 : retry_cnt;
        heal_n  = '0;
        irq_n   = 1'b0;
        total_n = fault_total;
        case (st)
            S_RST: begin
                st_n    = timer == '0 ? S_SETTLE : S_RST;
                timer_n = timer == '0 ? T_SET : timer - 1'b1;
            end
            S_SETTLE: begin
                st_n    = timer == '0 ? S_RUN : S_SETTLE;
                timer_n = timer - 1'b1;
            end
            S_RUN: begin
                if (hit) begin
                    // clear is already folded into retry_n, so a same-cycle clear lands on 1
                    irq_n   = 1'b1;
                    total_n = &fault_total ? fault_total : fault_total + 16'd1;
                    st_n    = retry_n == RETRY_MAX ? S_SAFE : S_RST;
                    retry_n = retry_n == RETRY_MAX ? retry_n : retry_n + 1'b1;
                    timer_n = T_RST;
                end else if (HEAL_CYCLES != 0) begin
                    heal_n  = heal == HEAL_LAST ? '0 : heal + 1'b1;
                    retry_n = heal == HEAL_LAST ? '0 : retry_n;
                end
            end
            S_SAFE: begin
                st_n    = fault_clr ? S_RST : S_SAFE;
                timer_n = fault_clr ? T_RST : timer;
            end
            default: st_n = S_RST;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= S_RST;
            timer       <= T_RST;
            retry_cnt   <= '0;
            fault_total <= '0;
            heal        <= '0;
            fault_irq   <= 1'b0;
        end else begin
            st          <= st_n;
            timer       <= timer_n;
            retry_cnt   <= retry_n;
            fault_total <= total_n;
            heal        <= heal_n;
            fault_irq   <= irq_n;
        end
    end
    assign core_rst = st == S_RST || st == S_SAFE;
    assign cmp_mask = st != S_RUN;
    assign fatal    = st == S_SAFE;
    assign state    = st;
endmodule
